// File: rtl/control_types.sv
// Shared EX-stage control encodings: ALU and M-extension operation enums
// plus small decode helpers used by the multiply/divide unit.
package control_types;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_t;

    // Encoded as funct3 so the decoder can pass it straight through
    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_t;

    function automatic logic mdu_is_div(input mdu_op_t op);
        return (op == MDU_DIV) || (op == MDU_DIVU) || (op == MDU_REM) || (op == MDU_REMU);
    endfunction

    function automatic logic mdu_is_rem(input mdu_op_t op);
        return (op == MDU_REM) || (op == MDU_REMU);
    endfunction

    function automatic logic mdu_a_signed(input mdu_op_t op);
        return (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    function automatic logic mdu_b_signed(input mdu_op_t op);
        return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate; used both for operand magnitude
// extraction and for final result sign correction.
module mdu_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         negate,
    output logic [W-1:0] result
);

    assign result = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide over XLEN cycles, with a one-cycle path for div-by-zero/overflow.
module mdu_iterative
    import control_types::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  mdu_op_t         op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            out_valid,
    output logic [XLEN-1:0] result
);

    localparam int CW = (XLEN > 2) ? $clog2(XLEN) : 1;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    state_t            state_reg, state_next;
    mdu_op_t           op_reg;
    logic              neg_reg;
    logic [CW-1:0]     cnt_reg;
    logic [XLEN-1:0]   opnd_reg;
    logic [2*XLEN-1:0] acc_reg;
    logic [XLEN-1:0]   result_reg;

    logic              accept, last_iter;
    logic              a_neg, b_neg, b_zero, div_ovf, fast;
    logic [XLEN-1:0]   a_abs, b_abs, fast_result, calc_result;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic              q_bit;
    logic [2*XLEN-1:0] mul_next, div_next, acc_step, fix_in, fix_out;

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign result    = result_reg;

    assign accept    = in_valid && in_ready && !flush;
    assign last_iter = (cnt_reg == CW'(XLEN - 1));

    // Operand magnitudes and the sign the final result must carry
    assign a_neg = mdu_a_signed(op) && operand_a[XLEN-1];
    assign b_neg = mdu_b_signed(op) && operand_b[XLEN-1];

    mdu_sign_fix #(.W(XLEN)) u_abs_a (.value(operand_a), .negate(a_neg), .result(a_abs));
    mdu_sign_fix #(.W(XLEN)) u_abs_b (.value(operand_b), .negate(b_neg), .result(b_abs));

    assign b_zero  = (operand_b == '0);
    assign div_ovf = ((op == MDU_DIV) || (op == MDU_REM)) &&
                     (operand_a == INT_MIN) && (operand_b == '1);
    assign fast    = mdu_is_div(op) && (b_zero || div_ovf);

    always_comb begin
        fast_result = operand_a;
        if (b_zero && !mdu_is_rem(op)) begin
            fast_result = '1;
        end else if (!b_zero && (op == MDU_REM)) begin
            fast_result = '0;
        end
    end

    // Multiply: acc = {partial high, remaining multiplier bits}, shifts right
    assign mul_sum  = {1'b0, acc_reg[2*XLEN-1:XLEN]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
    assign mul_next = {mul_sum, acc_reg[XLEN-1:1]};

    // Divide: acc = {remainder, dividend/quotient}, shifts left
    assign div_shift = {acc_reg[2*XLEN-1:XLEN], acc_reg[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opnd_reg};
    assign q_bit     = !div_diff[XLEN];
    assign div_next  = {(q_bit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                        acc_reg[XLEN-2:0], q_bit};

    assign acc_step = mdu_is_div(op_reg) ? div_next : mul_next;

    always_comb begin
        fix_in = acc_step;
        if (mdu_is_div(op_reg)) begin
            fix_in = {{XLEN{1'b0}}, (mdu_is_rem(op_reg) ? acc_step[2*XLEN-1:XLEN]
                                                        : acc_step[XLEN-1:0])};
        end
    end

    mdu_sign_fix #(.W(2*XLEN)) u_fix (.value(fix_in), .negate(neg_reg), .result(fix_out));

    always_comb begin
        calc_result = fix_out[XLEN-1:0];
        if ((op_reg == MDU_MULH) || (op_reg == MDU_MULHSU) || (op_reg == MDU_MULHU)) begin
            calc_result = fix_out[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: if (in_valid) state_next = fast ? ST_DONE : ST_CALC;
                ST_CALC: if (last_iter) state_next = ST_DONE;
                ST_DONE: state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // A flush on the edge that would enter DONE suppresses both pulse and result write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            op_reg     <= MDU_MUL;
            neg_reg    <= 1'b0;
            cnt_reg    <= '0;
            opnd_reg   <= '0;
            acc_reg    <= '0;
            result_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                op_reg   <= op;
                neg_reg  <= mdu_is_rem(op) ? a_neg : (a_neg ^ b_neg);
                cnt_reg  <= '0;
                opnd_reg <= mdu_is_div(op) ? b_abs : a_abs;
                acc_reg  <= {{XLEN{1'b0}}, (mdu_is_div(op) ? a_abs : b_abs)};
                if (fast) begin
                    result_reg <= fast_result;
                end
            end else if ((state_reg == ST_CALC) && !flush) begin
                acc_reg <= acc_step;
                cnt_reg <= cnt_reg + CW'(1);
                if (last_iter) begin
                    result_reg <= calc_result;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed self-checking bench for mdu_iterative at XLEN=32.
module tb_mdu_iterative;
    import control_types::*;

    localparam int XLEN = 32;
    localparam int ITER_LAT = XLEN + 1;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    mdu_op_t         op;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            flush;
    logic            out_valid;
    logic [XLEN-1:0] result;

    int checks = 0;
    int errors = 0;

    mdu_iterative #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .flush     (flush),
        .out_valid (out_valid),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one request, then count cycles to out_valid (bounded)
    task automatic do_op(input string tag, input mdu_op_t o, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp, input int lat);
        int n;
        int busy_ready;
        bit seen;
        @(negedge clk);
        check({tag, " ready"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; op = o; operand_a = a; operand_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0; busy_ready = 0; seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (out_valid) seen = 1'b1;
            else if (in_ready) busy_ready++;
        end
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " result"}, 64'(result), 64'(exp));
        if (lat > 1) check({tag, " busy"}, 64'(busy_ready), 64'd0);
        @(negedge clk);
        check({tag, " pulse"}, 64'(out_valid), 64'd0);
        $display("op %-8s a=%h b=%h result=%h cycles=%0d", tag, a, b, result, n);
    endtask

    // Accept an op, raise flush during CALC cycle k, expect no pulse afterwards
    task automatic flush_op(input string tag, input int k, input logic [XLEN-1:0] keep);
        int pulses;
        @(negedge clk);
        in_valid = 1'b1; op = MDU_MUL; operand_a = 32'd5; operand_b = 32'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < k; i++) @(negedge clk);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        check({tag, " ready"}, 64'(in_ready), 64'd1);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) pulses++;
            @(negedge clk);
        end
        check({tag, " pulses"}, 64'(pulses), 64'd0);
        check({tag, " result"}, 64'(result), 64'(keep));
        $display("flush %s at cycle %0d result=%h pulses=%0d", tag, k, result, pulses);
    endtask

    initial begin
        int n, busy_ready, pulses;
        bit seen;
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; op = MDU_MUL;
        operand_a = '0; operand_b = '0;
        repeat (3) @(negedge clk);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset result", 64'(result), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset in_ready", 64'(in_ready), 64'd1);

        do_op("MUL",    MDU_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, ITER_LAT);
        do_op("MULH",   MDU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, ITER_LAT);
        do_op("MULHU",  MDU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, ITER_LAT);
        do_op("MULHSU", MDU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, ITER_LAT);
        do_op("DIV",    MDU_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, ITER_LAT);
        do_op("REM",    MDU_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, ITER_LAT);
        do_op("DIVU",   MDU_DIVU,   32'd100,      32'd7,        32'd14,       ITER_LAT);
        do_op("REMU",   MDU_REMU,   32'd100,      32'd7,        32'd2,        ITER_LAT);
        do_op("DIV0",   MDU_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1);
        do_op("REMU0",  MDU_REMU,   32'd5,        32'd0,        32'd5,        1);
        do_op("DIVOVF", MDU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        do_op("REMOVF", MDU_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
        do_op("DIVU0",  MDU_DIVU,   32'd9,        32'd0,        32'hFFFFFFFF, 1);
        do_op("REM0",   MDU_REM,    32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1);

        // Last result is 0xFFFFFFF9; flushes must leave it untouched
        flush_op("calc10", 10, 32'hFFFFFFF9);
        flush_op("done", XLEN, 32'hFFFFFFF9);

        // Flush in IDLE blocks the request
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; op = MDU_DIVU; operand_a = 32'd100; operand_b = 32'd7;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("idle flush ready", 64'(in_ready), 64'd1);
        check("idle flush valid", 64'(out_valid), 64'd0);
        $display("flush idle in_ready=%0d", in_ready);

        // Reset mid-CALC discards the operation
        @(negedge clk);
        in_valid = 1'b1; op = MDU_DIVU; operand_a = 32'd100; operand_b = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst result", 64'(result), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        check("rst ready", 64'(in_ready), 64'd1);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("rst pulses", 64'(pulses), 64'd0);
        $display("reset mid-calc result=%h pulses=%0d", result, pulses);

        // Back-to-back with in_valid held high
        @(negedge clk);
        in_valid = 1'b1; op = MDU_DIVU; operand_a = 32'd100; operand_b = 32'd7;
        @(posedge clk); #1;
        op = MDU_MUL; operand_a = 32'd3; operand_b = 32'd4;
        n = 0; busy_ready = 0; seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (out_valid) seen = 1'b1;
            else if (in_ready) busy_ready++;
        end
        check("b2b first latency", 64'(n), 64'(ITER_LAT));
        check("b2b first result", 64'(result), 64'd14);
        check("b2b busy", 64'(busy_ready), 64'd0);
        check("b2b done ready", 64'(in_ready), 64'd0);
        $display("b2b DIVU result=%h cycles=%0d", result, n);
        @(negedge clk);
        check("b2b second accept", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0; seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (out_valid) seen = 1'b1;
        end
        check("b2b second latency", 64'(n), 64'(ITER_LAT));
        check("b2b second result", 64'(result), 64'd12);
        $display("b2b MUL result=%h cycles=%0d", result, n);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
